// File: rtl/apb_master_bridge.sv
// APB master bridge: single-outstanding core request to a 4-slave APB bus with registered completion pulse.
// Optional ACCESS-phase watchdog enabled by defining APB_MASTER_BRIDGE_TIMEOUT_EN.
module apb_master_bridge (
    input  logic        PCLK,
    input  logic        PRESET,
    // request group
    input  logic        req,
    input  logic        req_write,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        req_ready,
    // APB group
    output logic [31:0] PADDR,
    output logic        PWRITE,
    output logic [31:0] PWDATA,
    output logic        PENABLE,
    output logic [3:0]  PSEL,
    input  logic [31:0] PRDATA0,
    input  logic [31:0] PRDATA1,
    input  logic [31:0] PRDATA2,
    input  logic [31:0] PRDATA3,
    input  logic        PREADY0,
    input  logic        PREADY1,
    input  logic        PREADY2,
    input  logic        PREADY3,
    // response group
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SETUP,
        S_ACCESS
    } state_t;

    state_t      r_state;
    state_t      w_next;
    logic [31:0] r_addr;
    logic        r_write;
    logic [31:0] r_wdata;
    logic [1:0]  r_slave;
    logic        r_rsp_valid;
    logic        r_rsp_err;
    logic [31:0] r_rsp_rdata;

    logic        w_bad_addr;
    logic        w_ready;
    logic        w_accept;
    logic        w_decerr;
    logic        w_done;
    logic        w_timeout;
    logic        w_pready;
    logic [31:0] w_prdata;

`ifdef APB_MASTER_BRIDGE_TIMEOUT_EN
    logic [7:0]  r_cnt;
`endif

    assign w_bad_addr = (req_addr[15:14] != 2'b00);

    // A decode error answers one cycle later without leaving IDLE; holding it off while a
    // pulse is already out keeps two completion pulses from landing back to back.
    assign w_ready = (r_state == S_IDLE) && !(r_rsp_valid && w_bad_addr);

    always_comb begin
        w_pready = 1'b0;
        w_prdata = '0;
        case (r_slave)
            2'd0: begin w_pready = PREADY0; w_prdata = PRDATA0; end
            2'd1: begin w_pready = PREADY1; w_prdata = PRDATA1; end
            2'd2: begin w_pready = PREADY2; w_prdata = PRDATA2; end
            default: begin w_pready = PREADY3; w_prdata = PRDATA3; end
        endcase
    end

    always_comb begin
        w_next    = r_state;
        w_accept  = 1'b0;
        w_decerr  = 1'b0;
        w_done    = 1'b0;
        w_timeout = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (req && w_ready) begin
                    if (w_bad_addr) begin
                        w_decerr = 1'b1;
                    end else begin
                        w_accept = 1'b1;
                        w_next   = S_SETUP;
                    end
                end
            end
            S_SETUP: begin
                w_next = S_ACCESS;
            end
            S_ACCESS: begin
                if (w_pready) begin
                    w_done = 1'b1;
                    w_next = S_IDLE;
                end
`ifdef APB_MASTER_BRIDGE_TIMEOUT_EN
                else if (r_cnt == 8'd254) begin
                    w_timeout = 1'b1;
                    w_next    = S_IDLE;
                end
`endif
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            r_state     <= S_IDLE;
            r_addr      <= '0;
            r_write     <= 1'b0;
            r_wdata     <= '0;
            r_slave     <= '0;
            r_rsp_valid <= 1'b0;
            r_rsp_err   <= 1'b0;
            r_rsp_rdata <= '0;
        end else begin
            r_state <= w_next;
            if (w_accept) begin
                r_addr  <= req_addr;
                r_write <= req_write;
                r_wdata <= req_wdata;
                r_slave <= req_addr[13:12];
            end
            r_rsp_valid <= w_decerr | w_done | w_timeout;
            r_rsp_err   <= w_decerr | w_timeout;
            r_rsp_rdata <= (w_done && !r_write) ? w_prdata : '0;
        end
    end

`ifdef APB_MASTER_BRIDGE_TIMEOUT_EN
    // Counts stalled ACCESS cycles; the 255th stall (count 254 on entry) aborts.
    always_ff @(posedge PCLK) begin
        if (PRESET || r_state == S_SETUP) begin
            r_cnt <= '0;
        end else if (r_state == S_ACCESS && !w_pready) begin
            r_cnt <= r_cnt + 8'd1;
        end
    end
`endif

    assign req_ready = w_ready;
    assign PADDR     = r_addr;
    assign PWRITE    = r_write;
    assign PWDATA    = r_wdata;
    assign PENABLE   = (r_state == S_ACCESS);
    assign PSEL      = (r_state == S_IDLE) ? 4'b0000 : (4'b0001 << r_slave);
    assign rsp_valid = r_rsp_valid;
    assign rsp_err   = r_rsp_err;
    assign rsp_rdata = r_rsp_rdata;

endmodule

// File: tb/tb_apb_master_bridge.sv
// Scoreboard bench for apb_master_bridge: the driver pushes expected completions, a monitor pops them on rsp_valid.
module tb_apb_master_bridge;

    localparam int N = 60;

    logic        PCLK;
    logic        PRESET;
    logic        req;
    logic        req_write;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        req_ready;
    logic [31:0] PADDR;
    logic        PWRITE;
    logic [31:0] PWDATA;
    logic        PENABLE;
    logic [3:0]  PSEL;
    logic [31:0] prd [4];
    logic        prdy [4];
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    apb_master_bridge dut (
        .PCLK     (PCLK),
        .PRESET   (PRESET),
        .req      (req),
        .req_write(req_write),
        .req_addr (req_addr),
        .req_wdata(req_wdata),
        .req_ready(req_ready),
        .PADDR    (PADDR),
        .PWRITE   (PWRITE),
        .PWDATA   (PWDATA),
        .PENABLE  (PENABLE),
        .PSEL     (PSEL),
        .PRDATA0  (prd[0]),
        .PRDATA1  (prd[1]),
        .PRDATA2  (prd[2]),
        .PRDATA3  (prd[3]),
        .PREADY0  (prdy[0]),
        .PREADY1  (prdy[1]),
        .PREADY2  (prdy[2]),
        .PREADY3  (prdy[3]),
        .rsp_valid(rsp_valid),
        .rsp_rdata(rsp_rdata),
        .rsp_err  (rsp_err)
    );

    typedef struct {
        int unsigned cyc;
        logic        err;
        logic [31:0] rdata;
    } exp_t;

    exp_t        q [$];
    int unsigned cyc;
    int          checks;
    int          errors;

    logic        t_wr   [N+2];
    logic [31:0] t_addr [N+2];
    logic [31:0] t_wd   [N+2];
    int          t_wt   [N+2];
    logic [31:0] t_rd   [N+2];
    logic        t_b2b  [N+2];

    initial PCLK = 1'b0;
    always #5 PCLK = ~PCLK;

    initial begin
        cyc = 0;
        forever @(posedge PCLK) cyc++;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, actual=running required=done");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=%h required=%h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: pops one expected completion per rsp_valid pulse.
    initial begin
        logic prev_valid;
        exp_t e;
        prev_valid = 1'b0;
        forever begin
            @(negedge PCLK);
            if (rsp_valid === 1'b1) begin
                chk("rsp_not_consecutive", {31'd0, prev_valid}, 32'd0);
                if (q.size() == 0) begin
                    chk("rsp_unexpected", 32'd1, 32'd0);
                end else begin
                    e = q.pop_front();
                    chk("rsp_cycle", cyc, e.cyc);
                    chk("rsp_err", {31'd0, rsp_err}, {31'd0, e.err});
                    chk("rsp_rdata", rsp_rdata, e.rdata);
                end
            end
            prev_valid = (rsp_valid === 1'b1);
        end
    end

    task automatic junk(input int tgt);
        for (int s = 0; s < 4; s++) begin
            if (s != tgt) begin
                prd[s]  = $urandom;
                prdy[s] = 1'($urandom_range(0, 1));
            end
        end
    endtask

    task automatic drive_req(input int i);
        req       = 1'b1;
        req_write = t_wr[i];
        req_addr  = t_addr[i];
        req_wdata = t_wd[i];
    endtask

    task automatic wait_ready(output bit ok);
        int guard;
        guard = 0;
        while (req_ready !== 1'b1 && guard < 20) begin
            @(negedge PCLK);
            junk(-1);
            #1;
            guard++;
        end
        ok = (req_ready === 1'b1);
        if (!ok) chk("accept_timeout", {31'd0, req_ready}, 32'd1);
    endtask

    task automatic bus_chk(input int tgt, input logic en, input int i);
        logic [3:0] sel;
        sel = 4'b0001 << tgt;
        chk("psel", {28'd0, PSEL}, {28'd0, sel});
        chk("penable", {31'd0, PENABLE}, {31'd0, en});
        chk("paddr_stable", PADDR, t_addr[i]);
        chk("pwrite_stable", {31'd0, PWRITE}, {31'd0, t_wr[i]});
        chk("pwdata_stable", PWDATA, t_wd[i]);
        if (req === 1'b1) chk("busy_not_ready", {31'd0, req_ready}, 32'd0);
    endtask

    task automatic run_txn(input int i);
        int   tgt;
        bit   bad;
        bit   ok;
        int unsigned t;
        exp_t e;
        tgt = int'(t_addr[i][15:12]);
        bad = (tgt > 3);
        drive_req(i);
        junk(bad ? -1 : tgt);
        if (!bad) begin
            prd[tgt]  = $urandom;
            prdy[tgt] = 1'($urandom_range(0, 1));
        end
        #1;
        if (t_b2b[i]) chk("b2b_accept_immediate", {31'd0, req_ready}, 32'd1);
        wait_ready(ok);
        if (!ok) begin
            req = 1'b0;
            return;
        end
        t       = cyc;
        e.cyc   = bad ? t + 1 : t + 3 + t_wt[i];
        e.err   = bad;
        e.rdata = (bad || t_wr[i]) ? 32'd0 : t_rd[i];
        q.push_back(e);

        @(negedge PCLK);
        if (i + 1 < N && t_b2b[i+1]) drive_req(i + 1);
        else req = 1'b0;
        if (bad) begin
            junk(-1);
            #1;
            chk("decerr_no_psel", {28'd0, PSEL}, 32'd0);
            return;
        end
        junk(tgt);
        prdy[tgt] = 1'($urandom_range(0, 1));
        prd[tgt]  = $urandom;
        #1;
        bus_chk(tgt, 1'b0, i);
        for (int k = 0; k <= t_wt[i]; k++) begin
            @(negedge PCLK);
            junk(tgt);
            prdy[tgt] = (k == t_wt[i]);
            prd[tgt]  = (k == t_wt[i]) ? t_rd[i] : $urandom;
            #1;
            bus_chk(tgt, 1'b1, i);
        end
        @(negedge PCLK);
        prdy[tgt] = 1'b0;
        #1;
        chk("idle_psel", {28'd0, PSEL}, 32'd0);
        chk("idle_penable", {31'd0, PENABLE}, 32'd0);
    endtask

    initial begin
        bit ok;
        int unsigned t;
        exp_t e;
        checks = 0;
        errors = 0;
        PRESET = 1'b1;
        req = 1'b0;
        req_write = 1'b0;
        req_addr = '0;
        req_wdata = '0;
        for (int s = 0; s < 4; s++) begin
            prd[s]  = '0;
            prdy[s] = 1'b0;
        end

        t_wr[0] = 1'b1; t_addr[0] = 32'h0000_0000; t_wd[0] = 32'h0000_04D2; t_wt[0] = 1; t_rd[0] = 32'h1234_5678; t_b2b[0] = 1'b0;
        t_wr[1] = 1'b0; t_addr[1] = 32'h0000_2004; t_wd[1] = 32'h0;         t_wt[1] = 0; t_rd[1] = 32'hCAFE_F00D; t_b2b[1] = 1'b0;
        t_wr[2] = 1'b0; t_addr[2] = 32'h0000_5000; t_wd[2] = 32'h0;         t_wt[2] = 0; t_rd[2] = 32'h0;         t_b2b[2] = 1'b0;
        t_wr[3] = 1'b0; t_addr[3] = 32'h0000_1010; t_wd[3] = 32'h0;         t_wt[3] = 0; t_rd[3] = 32'hA5A5_0001; t_b2b[3] = 1'b0;
        t_wr[4] = 1'b1; t_addr[4] = 32'h0000_3008; t_wd[4] = 32'h0BAD_BEEF; t_wt[4] = 2; t_rd[4] = 32'h0;         t_b2b[4] = 1'b1;
        for (int i = 5; i < N; i++) begin
            logic [3:0] nib;
            nib       = 4'($urandom_range(0, 5));
            t_wr[i]   = 1'($urandom_range(0, 1));
            t_addr[i] = {$urandom_range(0, 65535) & 32'hFFFF, 16'h0} | {16'h0, nib, 12'($urandom)};
            t_wd[i]   = $urandom;
            t_wt[i]   = $urandom_range(0, 4);
            t_rd[i]   = $urandom;
            t_b2b[i]  = (nib < 4) && ($urandom_range(0, 2) == 0);
        end
        t_wr[N] = 1'b0; t_addr[N] = 32'h0000_1000; t_wd[N] = 32'h0; t_wt[N] = 1000; t_rd[N] = 32'h1357_9BDF; t_b2b[N] = 1'b0;
        t_wr[N+1] = 1'b0; t_addr[N+1] = 32'h0000_1000; t_wd[N+1] = 32'h0; t_wt[N+1] = 254; t_rd[N+1] = 32'h2468_ACE0; t_b2b[N+1] = 1'b0;

        repeat (3) @(negedge PCLK);
        chk("rst_psel", {28'd0, PSEL}, 32'd0);
        chk("rst_penable", {31'd0, PENABLE}, 32'd0);
        chk("rst_pwrite", {31'd0, PWRITE}, 32'd0);
        chk("rst_paddr", PADDR, 32'd0);
        chk("rst_pwdata", PWDATA, 32'd0);
        chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        chk("rst_rsp_err", {31'd0, rsp_err}, 32'd0);
        chk("rst_rsp_rdata", rsp_rdata, 32'd0);
        PRESET = 1'b0;
        #1;
        chk("ready_after_reset", {31'd0, req_ready}, 32'd1);

        for (int i = 0; i < N; i++) begin
            run_txn(i);
            if (i + 1 < N && !t_b2b[i+1]) begin
                req = 1'b0;
                repeat ($urandom_range(0, 2)) @(negedge PCLK);
            end
        end
        req = 1'b0;
        repeat (2) @(negedge PCLK);

        // Reset pulsed in the middle of an ACCESS phase aborts without a response.
        req = 1'b1; req_write = 1'b1; req_addr = 32'h0000_3010; req_wdata = 32'h0000_0055;
        for (int s = 0; s < 4; s++) prdy[s] = 1'b0;
        #1;
        wait_ready(ok);
        @(negedge PCLK);
        req = 1'b0;
        @(negedge PCLK);
        @(negedge PCLK);
        #1;
        chk("midrst_in_access", {31'd0, PENABLE}, 32'd1);
        PRESET = 1'b1;
        @(negedge PCLK);
        chk("midrst_psel", {28'd0, PSEL}, 32'd0);
        chk("midrst_penable", {31'd0, PENABLE}, 32'd0);
        chk("midrst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        chk("midrst_paddr", PADDR, 32'd0);
        PRESET = 1'b0;
        #1;
        chk("midrst_ready", {31'd0, req_ready}, 32'd1);
        @(negedge PCLK);

`ifdef APB_MASTER_BRIDGE_TIMEOUT_EN
        begin
            int stalled;
            req = 1'b1; req_write = 1'b0; req_addr = 32'h0000_1000; req_wdata = 32'h0;
            prdy[1] = 1'b0;
            #1;
            wait_ready(ok);
            t = cyc;
            e.cyc = t + 257; e.err = 1'b1; e.rdata = 32'd0;
            q.push_back(e);
            @(negedge PCLK);
            req = 1'b0;
            stalled = 0;
            for (int k = 0; k < 255; k++) begin
                @(negedge PCLK);
                junk(1);
                prdy[1] = 1'b0;
                #1;
                if (PENABLE === 1'b1 && PSEL === 4'b0010) stalled++;
            end
            chk("timeout_access_cycles", stalled, 32'd255);
            @(negedge PCLK);
            #1;
            chk("timeout_psel_drop", {28'd0, PSEL}, 32'd0);
        end
        run_txn(N + 1);
`else
        run_txn(N);
`endif
        req = 1'b0;
        repeat (5) @(negedge PCLK);
        chk("scoreboard_drained", q.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
